// File: rtl/pulse_train_gen.sv
// pulse_train_gen: trigger-started multi-channel pulse generator.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : block enable, low forces idle
//   tem         : asynchronous trigger, rising edge starts a burst
//   period      : repetition period in clk cycles
//   delay/width : per-channel offset and width, channel i at [i*CNT_W +: CNT_W]
//   burst       : periods per trigger, 0 = continuous
//   abort       : synchronous stop request
//   pulse_out   : registered channel outputs (bit 0 = K1)
//   busy        : high while running
//   done        : one-cycle strobe at finite burst completion
//   cfg_err     : one-cycle strobe when a trigger is rejected
module pulse_train_gen #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   tem,
  input  logic [CNT_W-1:0]       period,
  input  logic [NCH*CNT_W-1:0]   delay,
  input  logic [NCH*CNT_W-1:0]   width,
  input  logic [15:0]            burst,
  input  logic                   abort,
  output logic [NCH-1:0]         pulse_out,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   prev_q, prev_d;
  logic                   trig_q, trig_d;
  logic [CNT_W-1:0]       pcnt_q, pcnt_d;
  logic [15:0]            bcnt_q, bcnt_d;
  logic [CNT_W-1:0]       per_q, per_d;
  logic [NCH*CNT_W-1:0]   dly_q, dly_d;
  logic [NCH*CNT_W-1:0]   wid_q, wid_d;
  logic [15:0]            burst_q, burst_d;
  logic [NCH-1:0]         pulse_q, pulse_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   cfg_ok;
  logic                   stop;
  logic [NCH-1:0]         act;
  logic [16:0]            bcnt_inc;

  // vld_q marks synchroniser stages holding a real post-reset sample; prev_q
  // idles high so a tem already high at reset release is not seen as an edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tem};
    vld_d  = {vld_q[SYNC_STAGES-2:0], 1'b1};
    prev_d = vld_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
    trig_d = vld_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_comb begin
    cfg_ok = (period >= CNT_W'(2));
    for (int unsigned i = 0; i < NCH; i++) begin
      if (({1'b0, delay[i*CNT_W +: CNT_W]} + {1'b0, width[i*CNT_W +: CNT_W]})
          > {1'b0, period})
        cfg_ok = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      act[i] = (pcnt_q >= dly_q[i*CNT_W +: CNT_W]) &&
               ({1'b0, pcnt_q} < ({1'b0, dly_q[i*CNT_W +: CNT_W]} +
                                  {1'b0, wid_q[i*CNT_W +: CNT_W]}));
    end
  end

  assign stop     = abort | ~enable;
  assign bcnt_inc = {1'b0, bcnt_q} + 17'd1;

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    bcnt_d    = bcnt_q;
    per_d     = per_q;
    dly_d     = dly_q;
    wid_d     = wid_q;
    burst_d   = burst_q;
    pulse_d   = '0;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_q && !stop) begin
          if (cfg_ok) begin
            state_d = ST_RUN;
            pcnt_d  = '0;
            bcnt_d  = '0;
            per_d   = period;
            dly_d   = delay;
            wid_d   = width;
            burst_d = burst;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          pulse_d = act;
          if (pcnt_q == per_q - CNT_W'(1)) begin
            pcnt_d = '0;
            if (bcnt_q != '1)
              bcnt_d = bcnt_inc[15:0];
            if ((burst_q != '0) && (bcnt_inc == {1'b0, burst_q}))
              state_d = ST_DONE;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sync_q    <= '0;
      vld_q     <= '0;
      prev_q    <= 1'b1;
      trig_q    <= 1'b0;
      pcnt_q    <= '0;
      bcnt_q    <= '0;
      per_q     <= '0;
      dly_q     <= '0;
      wid_q     <= '0;
      burst_q   <= '0;
      pulse_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      vld_q     <= vld_d;
      prev_q    <= prev_d;
      trig_q    <= trig_d;
      pcnt_q    <= pcnt_d;
      bcnt_q    <= bcnt_d;
      per_q     <= per_d;
      dly_q     <= dly_d;
      wid_q     <= wid_d;
      burst_q   <= burst_d;
      pulse_q   <= pulse_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign cfg_err   = cfg_err_q;

endmodule
